// File: rtl/mac_operand_loader.sv
// Operand feeder and result collector for the complex MAC: loads eight packed
// operand bytes, starts the MAC, captures its result and hands it downstream.
module mac_operand_loader #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] x0,
   output logic [DATA_W-1:0] x1,
   output logic [DATA_W-1:0] x2,
   output logic [DATA_W-1:0] x3,
   output logic [DATA_W-1:0] y0,
   output logic [DATA_W-1:0] y1,
   output logic [DATA_W-1:0] y2,
   output logic [DATA_W-1:0] y3,
   output logic              mac_start,
   input  logic              mac_done,
   input  logic [ACC_W-1:0]  mac_out,
   output logic [ACC_W-1:0]  res_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              busy,
   output logic [7:0]        op_count
);

   typedef enum logic [1:0] {StLoad, StStart, StWaitDone, StHold} state_e;

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] opnd_q [8];
   logic [DATA_W-1:0] opnd_d [8];
   logic [ACC_W-1:0]  res_q, res_d;
   logic              res_valid_q, res_valid_d;
   logic [7:0]        op_count_q, op_count_d;

   // Operand slots interleave x and y in arrival order: x0 y0 x1 y1 ...
   assign x0 = opnd_q[0];
   assign y0 = opnd_q[1];
   assign x1 = opnd_q[2];
   assign y1 = opnd_q[3];
   assign x2 = opnd_q[4];
   assign y2 = opnd_q[5];
   assign x3 = opnd_q[6];
   assign y3 = opnd_q[7];

   assign res_data  = res_q;
   assign res_valid = res_valid_q;
   assign op_count  = op_count_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      opnd_d      = opnd_q;
      res_d       = res_q;
      res_valid_d = res_valid_q;
      op_count_d  = op_count_q;
      in_ready    = 1'b0;
      mac_start   = 1'b0;
      busy        = 1'b1;

      unique case (state_q)
         StLoad: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               opnd_d[cnt_q] = in_data;
               // 3-bit counter wraps 7 -> 0 on the last byte
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  state_d = StStart;
               end
            end
         end
         StStart: begin
            mac_start = 1'b1;
            // The MAC acknowledges by dropping its idle level
            if (!mac_done) begin
               state_d = StWaitDone;
            end
         end
         StWaitDone: begin
            if (mac_done) begin
               res_d       = mac_out;
               res_valid_d = 1'b1;
               state_d     = StHold;
            end
         end
         StHold: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               op_count_d  = op_count_q + 8'd1;
               state_d     = StLoad;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StLoad;
         cnt_q       <= 3'd0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         op_count_q  <= 8'd0;
         for (int i = 0; i < 8; i++) begin
            opnd_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
         op_count_q  <= op_count_d;
         for (int i = 0; i < 8; i++) begin
            opnd_q[i] <= opnd_d[i];
         end
      end
   end

endmodule
